// File: rtl/handshake_sender.sv
// handshake_sender: FIFO-buffered upstream side of a 4-phase req/ack byte link,
// with an optional sticky ack-timeout abort.
module handshake_sender #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 4,
   parameter int ACK_TIMEOUT = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    in_ready,
   input  logic                    enableTx,
   input  logic                    ack,
   output logic                    req,
   output logic [DATA_WIDTH-1:0]   data,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [15:0]             words_sent,
   output logic                    timeout_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);
   localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, REQ_HI = 2'd2, REQ_LO = 2'd3;

   logic [1:0]            state;
   logic [AW-1:0]         wrPtr, rdPtr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [TW-1:0]         waitCnt;
   logic                  push, pop, expired;

   always_comb begin
      in_ready = fifo_count != (AW+1)'(DEPTH);
      push     = in_valid & in_ready;
      pop      = state == IDLE && fifo_count != 0 && enableTx && !ack;
      expired  = ACK_TIMEOUT > 0 && waitCnt == T_LAST;
   end

   always_ff @(posedge clk)
      if (push) mem[wrPtr] <= in_data;

   // waitCnt reaching T_LAST means this edge is the ACK_TIMEOUT-th cycle spent waiting
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         req         <= 1'b0;
         data        <= '0;
         wrPtr       <= '0;
         rdPtr       <= '0;
         fifo_count  <= '0;
         words_sent  <= '0;
         timeout_err <= 1'b0;
         waitCnt     <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop) rdPtr <= rdPtr + AW'(1);
         fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
         case (state)
            IDLE:
               if (pop) begin
                  data  <= mem[rdPtr];
                  state <= SETUP;
               end
            SETUP: begin
               req     <= 1'b1;
               waitCnt <= '0;
               state   <= REQ_HI;
            end
            REQ_HI:
               if (ack) begin
                  req     <= 1'b0;
                  waitCnt <= '0;
                  state   <= REQ_LO;
               end else if (expired) begin
                  req         <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else waitCnt <= waitCnt + TW'(1);
            REQ_LO:
               if (!ack) begin
                  words_sent <= words_sent + 16'd1;
                  state      <= IDLE;
               end else if (expired) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else waitCnt <= waitCnt + TW'(1);
         endcase
      end
   end
endmodule
